// File: rtl/fx_pkg.sv
// -----------------------------------------------------------------------------
// fx_pkg
// Shared definitions for the delay/mix effect block.
//   fx_mode_e    : mixing mode (FX_MODE_ECHO adds, FX_MODE_PHASER subtracts)
//   FX_SAT_W     : widest sample width the saturate helper supports
//   fx_saturate  : clamps a sign-extended sum to the signed range of w bits
// No ports (package).
// -----------------------------------------------------------------------------
package fx_pkg;

    typedef enum logic {
        FX_MODE_ECHO   = 1'b0,
        FX_MODE_PHASER = 1'b1
    } fx_mode_e;

    localparam int FX_SAT_W = 32;

    // Clamp s to [-2^(w-1), 2^(w-1)-1]. The caller sign-extends its sum into
    // FX_SAT_W+1 bits and truncates the result back to w bits.
    function automatic logic signed [FX_SAT_W:0] fx_saturate(
        input logic signed [FX_SAT_W:0] s,
        input int unsigned              w
    );
        logic signed [FX_SAT_W:0] hi;
        logic signed [FX_SAT_W:0] lo;
        hi = '0;
        for (int i = 0; i < FX_SAT_W; i++) begin
            if (i < int'(w) - 1) begin
                hi[i] = 1'b1;
            end
        end
        lo = ~hi;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/fx_delay_mix_if.sv
// -----------------------------------------------------------------------------
// fx_delay_mix_if
// Sample stream and control bundle for fx_delay_mix.
//   en        : 1 = effect applied, 0 = bypass
//   mode      : 1 = phaser (subtract), 0 = echo (add)
//   delay     : delay tap in samples (0 behaves as 1)
//   in_valid  : in_audio carries a new sample (en/mode/delay sampled with it)
//   in_audio  : signed input sample
//   out_valid : one-cycle strobe, out_audio valid
//   out_audio : signed processed sample
// Modports: master drives the stream (source side), slave is the effect block.
// -----------------------------------------------------------------------------
interface fx_delay_mix_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                     en;
    logic                     mode;
    logic [ADDR_W-1:0]        delay;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_audio;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_audio;

    modport master (
        output en, mode, delay, in_valid, in_audio,
        input  out_valid, out_audio
    );

    modport slave (
        input  en, mode, delay, in_valid, in_audio,
        output out_valid, out_audio
    );
endinterface

// File: rtl/fx_delay_ram.sv
// -----------------------------------------------------------------------------
// fx_delay_ram
// Simple dual-port DEPTH x DATA_W RAM, one write port and one registered read
// port. A read and a write to the same address in one cycle return the old
// contents. No reset on the array.
// Ports:
//   clk        : rising-edge clock
//   wr_en_i    : write enable
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read enable (rd_data_o holds its value otherwise)
//   rd_addr_i  : read address
//   rd_data_o  : read data, valid the cycle after rd_en_i
// -----------------------------------------------------------------------------
module fx_delay_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fx_delay_mix.sv
// -----------------------------------------------------------------------------
// fx_delay_mix
// Delay-line echo/phaser. Each accepted sample x is written to a circular
// buffer; the sample eff_delay = max(delay,1) positions back (d) is read and
// combined as x+d (echo) or x-d (phaser), saturated to DATA_W bits. While
// fewer than eff_delay samples have been accepted since reset, d is 0.
// Pipeline: S1 = RAM read/write, S2 = combine/saturate; out_valid follows the
// accepting in_valid by exactly 2 cycles, with full throughput.
// Build option FX_DELAY_FEEDBACK_EN: when defined the buffer stores the
// effect output (repeating echo); when undefined it stores the dry input.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fx_delay_mix_if.slave (stream, control and result)
// -----------------------------------------------------------------------------
module fx_delay_mix
    import fx_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    fx_delay_mix_if.slave bus
);

    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);

    // Write pointer and fill level (samples accepted since reset, saturating)
    logic [ADDR_W-1:0]        wr_ptr_q;
    logic [ADDR_W-1:0]        wr_ptr_d;
    logic [ADDR_W:0]          fill_q;
    logic [ADDR_W:0]          fill_d;
    logic [ADDR_W-1:0]        eff_delay;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     d_zero;

    // S1 registers: the accepted sample and the controls sampled with it
    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] s1_x_q;
    fx_mode_e                 s1_mode_q;
    logic                     s1_en_q;
    logic                     s1_zero_q;

    // S2 registers
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_audio_q;

    // S2 datapath
    logic signed [DATA_W-1:0] ram_rd_data;
    logic signed [DATA_W-1:0] d;
    logic signed [DATA_W:0]   s_wide;
    logic signed [DATA_W-1:0] y;

    // RAM write port
    logic                     ram_wr_en;
    logic [ADDR_W-1:0]        ram_wr_addr;
    logic signed [DATA_W-1:0] ram_wr_data;

`ifdef FX_DELAY_FEEDBACK_EN
    // The effect output of a sample is written one cycle after its read, so a
    // back-to-back sample at delay 1 would read the location while that write
    // is still pending. Those reads take the value from the S2 result instead.
    logic [ADDR_W-1:0]        s1_addr_q;
    logic                     fwd_hit_q;
    logic signed [DATA_W-1:0] fwd_data_q;
`endif

    // S1 addressing and bookkeeping
    always_comb begin
        eff_delay = (bus.delay == '0) ? ADDR_W'(1) : bus.delay;
        rd_addr   = wr_ptr_q - eff_delay;     // wraps mod DEPTH (power of two)
        d_zero    = ({1'b0, eff_delay} > fill_q);
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        if (bus.in_valid) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + (ADDR_W+1)'(1);
            end
        end
    end

    // S2 combine and saturate
    always_comb begin
`ifdef FX_DELAY_FEEDBACK_EN
        d = s1_zero_q ? '0 : (fwd_hit_q ? fwd_data_q : ram_rd_data);
`else
        d = s1_zero_q ? '0 : ram_rd_data;
`endif
        if (s1_mode_q == FX_MODE_PHASER) begin
            s_wide = $signed({s1_x_q[DATA_W-1], s1_x_q}) - $signed({d[DATA_W-1], d});
        end else begin
            s_wide = $signed({s1_x_q[DATA_W-1], s1_x_q}) + $signed({d[DATA_W-1], d});
        end
        y = s1_en_q ? DATA_W'(fx_saturate((FX_SAT_W+1)'(s_wide), DATA_W)) : s1_x_q;
    end

    // RAM write source
    always_comb begin
`ifdef FX_DELAY_FEEDBACK_EN
        ram_wr_en   = s1_valid_q;
        ram_wr_addr = s1_addr_q;
        ram_wr_data = y;
`else
        ram_wr_en   = bus.in_valid;
        ram_wr_addr = wr_ptr_q;
        ram_wr_data = bus.in_audio;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_audio_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            s1_valid_q  <= bus.in_valid;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_audio_q <= y;
            end
        end
    end

    // Datapath registers need no reset: the valid bits qualify them
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            s1_x_q    <= bus.in_audio;
            s1_mode_q <= fx_mode_e'(bus.mode);
            s1_en_q   <= bus.en;
            s1_zero_q <= d_zero;
`ifdef FX_DELAY_FEEDBACK_EN
            s1_addr_q  <= wr_ptr_q;
            fwd_hit_q  <= s1_valid_q && (rd_addr == s1_addr_q);
            fwd_data_q <= y;
`endif
        end
    end

    fx_delay_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (bus.in_valid),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rd_data)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_audio = out_audio_q;

endmodule

// File: tb/tb_fx_delay_mix.sv
// -----------------------------------------------------------------------------
// tb_fx_delay_mix
// Self-checking bench for fx_delay_mix (DATA_W=16, DEPTH=8). A reference model
// keeps the history of stored samples since reset and predicts each output and
// the cycle it must appear in; a negedge monitor matches every out_valid
// against that prediction. Directed sequences are also checked against
// hand-computed constant lists. Honours FX_DELAY_FEEDBACK_EN like the design.
// -----------------------------------------------------------------------------
module tb_fx_delay_mix;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t exp_q[$];
    int   hist[$];
    int   obs_q[$];
    exp_t mon_e;

    fx_delay_mix_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fx_delay_mix #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample and predict its output from the stored-sample history
    task automatic send(input int x, input int dly, input int md, input int e);
        int n, eff, dv, s, y;
        bus.in_valid = 1'b1;
        bus.in_audio = DATA_W'(x);
        bus.delay    = ADDR_W'(dly);
        bus.mode     = md[0];
        bus.en       = e[0];
        n   = hist.size();
        eff = (dly == 0) ? 1 : dly;
        dv  = (eff > n) ? 0 : hist[n - eff];
        s   = (md != 0) ? x - dv : x + dv;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        y = (e != 0) ? s : x;
`ifdef FX_DELAY_FEEDBACK_EN
        hist.push_back(y);
`else
        hist.push_back(x);
`endif
        exp_q.push_back('{due: cyc + 2, val: y});
        tick();
    endtask

    // Idle cycle: other inputs get junk, which must be ignored
    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_audio = DATA_W'($urandom);
        bus.delay    = ADDR_W'($urandom);
        bus.mode     = 1'($urandom);
        bus.en       = 1'($urandom);
        tick();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        // outputs due after the reset edge are dropped by the design
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) begin
            void'(exp_q.pop_back());
        end
        hist.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (4) idle();
    endtask

    task automatic check_obs(input string tag, input int exp_l[$]);
        check_val({tag, "_count"}, obs_q.size(), exp_l.size());
        foreach (exp_l[i]) begin
            if (i < obs_q.size()) begin
                check_val(tag, obs_q[i], exp_l[i]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            obs_q.push_back(int'(bus.out_audio));
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", bus.out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn cycle=%0d out=%0d expected=%0d due=%0d",
                         cyc, bus.out_audio, mon_e.val, mon_e.due);
                check_val("out_cycle", cyc, mon_e.due);
                check_val("out_audio", bus.out_audio, mon_e.val);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            check_val("missing_valid", bus.out_valid, 1);
        end
    end

    initial begin
        int exp_l[$];
        int r;
        bus.in_valid = 1'b0;
        bus.in_audio = '0;
        bus.delay    = '0;
        bus.mode     = 1'b0;
        bus.en       = 1'b0;

        do_reset();
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_audio", bus.out_audio, 0);

        // Impulse, delay 3
        obs_q.delete();
        send(1000, 3, 0, 1);
        repeat (5) send(0, 3, 0, 1);
        drain();
        exp_l = '{1000, 0, 0, 1000, 0, 0};
        check_obs("impulse", exp_l);

        // Saturation at both rails
        do_reset();
        obs_q.delete();
        send(30000, 1, 0, 1);
        send(30000, 1, 0, 1);
        send(-30000, 1, 1, 1);
        drain();
        exp_l = '{30000, 32767, -32768};
        check_obs("saturate", exp_l);

        // Pointer wrap, delay 7, continuous ramp
        do_reset();
        obs_q.delete();
        for (int n = 1; n <= 20; n++) send(n, 7, 0, 1);
        drain();
`ifndef FX_DELAY_FEEDBACK_EN
        exp_l.delete();
        for (int n = 1; n <= 20; n++) exp_l.push_back((n <= 7) ? n : 2 * n - 7);
        check_obs("wrap", exp_l);
`endif

        // Reset mid-stream drops the in-flight samples
        do_reset();
        for (int n = 11; n <= 15; n++) send(n, 2, 0, 1);
        do_reset();
        obs_q.delete();
        send(100, 2, 0, 1);
        drain();
        exp_l = '{100};
        check_obs("mid_reset", exp_l);

        // Bypass and delay=0 acting as delay=1
        do_reset();
        obs_q.delete();
        send(500, 1, 0, 1);
        send(-5, 1, 0, 0);
        send(7, 0, 0, 1);
        drain();
        exp_l = '{500, -5, 2};
        check_obs("bypass_d0", exp_l);

        // Delay change applies to the next accepted sample only
        do_reset();
        obs_q.delete();
        send(1, 1, 0, 1);
        send(2, 1, 0, 1);
        send(3, 1, 0, 1);
        send(4, 3, 0, 1);
        drain();
        exp_l = '{1, 3, 5, 5};
        check_obs("delay_change", exp_l);

        // Feedback behaviour, delay 2
        do_reset();
        obs_q.delete();
        send(1000, 2, 0, 1);
        repeat (5) send(0, 2, 0, 1);
        drain();
`ifdef FX_DELAY_FEEDBACK_EN
        exp_l = '{1000, 0, 1000, 0, 1000, 0};
`else
        exp_l = '{1000, 0, 1000, 0, 0, 0};
`endif
        check_obs("feedback", exp_l);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25) begin
                idle();
            end else if (r < 27) begin
                do_reset();
            end else begin
                send(int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, 1)),
                     (r < 35) ? 0 : 1);
            end
        end
        drain();
        check_val("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
